// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: RV32 width codes,
// FSM state encoding and the access legality / byte-lane helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Misaligned halves/words, reserved width codes and unsigned-width stores are refused.
  function automatic logic accessFault(input logic we, input logic [1:0] addrLo,
                                       input logic [2:0] f3);
    logic f;
    f = 1'b0;
    case (f3)
      F3_B, F3_BU: f = 1'b0;
      F3_H, F3_HU: f = addrLo[0];
      F3_W:        f = (addrLo != 2'b00);
      default:     f = 1'b1;
    endcase
    if (we && f3[2]) f = 1'b1;
    return f;
  endfunction

  function automatic logic [3:0] laneMask(input logic [1:0] addrLo, input logic [2:0] f3);
    logic [3:0] m;
    m = 4'b1111;
    case (f3)
      F3_B:    m = 4'b0001 << addrLo;
      F3_H:    m = addrLo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign shifted = word_i >> {addr_i, 3'b000};
  assign byteSel = shifted[7:0];
  assign halfSel = addr_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byteSel[7]}}, byteSel};
      F3_BU:   data_o = {24'h0, byteSel};
      F3_H:    data_o = {{16{halfSel[15]}}, halfSel};
      F3_HU:   data_o = {16'h0, halfSel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// programmable wait states, registered response with fault flagging.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                reqWe_q;
  logic [ADDR_W+1:0]   reqAddr_q;
  logic [31:0]         reqWdata_q;
  logic [2:0]          reqF3_q;
  logic                rspValid_q;
  logic [31:0]         rspRdata_q;
  logic                rspFault_q;

  logic [31:0]         mem [0:2**ADDR_W-1];

  logic                accept;
  logic                reqFault;
  logic                commit;
  logic [ADDR_W-1:0]   wordIdx;
  logic [3:0]          storeMask;
  logic [31:0]         storeData;
  logic [31:0]         loadData;
  logic                unusedAddrBits;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_fault = rspFault_q;

  assign accept   = req_valid && req_ready;
  assign reqFault = accessFault(req_we, req_addr[1:0], req_funct3);
  assign commit   = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // High address bits are intentionally dropped so the array aliases modulo its depth.
  assign unusedAddrBits = ^req_addr[31:ADDR_W+2];
  assign wordIdx        = reqAddr_q[ADDR_W+1:2];
  assign storeMask      = laneMask(reqAddr_q[1:0], reqF3_q);

  always_comb begin
    storeData = reqWdata_q;
    case (reqF3_q)
      F3_B:    storeData = {4{reqWdata_q[7:0]}};
      F3_H:    storeData = {2{reqWdata_q[15:0]}};
      default: storeData = reqWdata_q;
    endcase
  end

  dmem_load_align u_align (
    .word_i   (mem[wordIdx]),
    .addr_i   (reqAddr_q[1:0]),
    .funct3_i (reqF3_q),
    .data_o   (loadData)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reqFault) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      reqWe_q    <= 1'b0;
      reqAddr_q  <= '0;
      reqWdata_q <= 32'h0;
      reqF3_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        reqWe_q    <= req_we;
        reqAddr_q  <= req_addr[ADDR_W+1:0];
        reqWdata_q <= req_wdata;
        reqF3_q    <= req_funct3;
      end
    end
  end

  // The response pulse lines up with the RESP state: set on the edge that enters it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rspValid_q <= 1'b0;
      rspRdata_q <= 32'h0;
      rspFault_q <= 1'b0;
    end else begin
      rspValid_q <= 1'b0;
      if (accept && reqFault) begin
        rspValid_q <= 1'b1;
        rspFault_q <= 1'b1;
        rspRdata_q <= 32'h0;
      end else if (commit) begin
        rspValid_q <= 1'b1;
        rspFault_q <= 1'b0;
        rspRdata_q <= reqWe_q ? 32'h0 : loadData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && reqWe_q) begin
      for (int i = 0; i < 4; i++) begin
        if (storeMask[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: three instances cover the default,
// zero and three wait-state configurations.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [2:0]  reqFunct3;
  int          sel;

  logic        valid0, valid1, valid2;
  logic        ready0, ready1, ready2;
  logic        rspValid0, rspValid1, rspValid2;
  logic [31:0] rspRdata0, rspRdata1, rspRdata2;
  logic        rspFault0, rspFault1, rspFault2;
  logic        busy0, busy1, busy2;

  logic        obsReady, obsValid, obsFault, obsBusy;
  logic [31:0] obsRdata;

  exp_t        sbQ[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign valid0 = reqValid && (sel == 0);
  assign valid1 = reqValid && (sel == 1);
  assign valid2 = reqValid && (sel == 2);

  assign obsReady = (sel == 1) ? ready1    : (sel == 2) ? ready2    : ready0;
  assign obsValid = (sel == 1) ? rspValid1 : (sel == 2) ? rspValid2 : rspValid0;
  assign obsRdata = (sel == 1) ? rspRdata1 : (sel == 2) ? rspRdata2 : rspRdata0;
  assign obsFault = (sel == 1) ? rspFault1 : (sel == 2) ? rspFault2 : rspFault0;
  assign obsBusy  = (sel == 1) ? busy1     : (sel == 2) ? busy2     : busy0;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_funct3(reqFunct3),
    .rsp_valid(rspValid0), .rsp_rdata(rspRdata0), .rsp_fault(rspFault0), .busy(busy0)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dutW0 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_funct3(reqFunct3),
    .rsp_valid(rspValid1), .rsp_rdata(rspRdata1), .rsp_fault(rspFault1), .busy(busy1)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dutW3 (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_ready(ready2), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_funct3(reqFunct3),
    .rsp_valid(rspValid2), .rsp_rdata(rspRdata2), .rsp_fault(rspFault2), .busy(busy2)
  );

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives a request, records its expected response and confirms acceptance in this cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic [31:0] expRdata,
                               input logic expFault, input int expLat);
    int waited;
    reqWe     = we;
    reqAddr   = addr;
    reqWdata  = wdata;
    reqFunct3 = f3;
    reqValid  = 1'b1;
    sbQ.push_back('{rdata: expRdata, fault: expFault, lat: 32'(expLat)});
    #1;
    waited = 0;
    while (!obsReady && waited < 20) begin
      stepCycle();
      waited++;
    end
    compare("acceptWait", 32'(waited), 32'd0);
  endtask

  // Waits for the response, compares it against the scoreboard head and checks the pulse shape.
  task automatic checkOutput(input string tag, input bit holdValid);
    exp_t exp;
    int   n;
    bit   seen;
    if (sbQ.size() == 0) begin
      compare({tag, ".sbEmpty"}, 32'd1, 32'd0);
      return;
    end
    exp  = sbQ.pop_front();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      stepCycle();
      n++;
      if (!holdValid) reqValid = 1'b0;
      compare({tag, ".readyLow"}, 32'(obsReady), 32'd0);
      if (obsValid) begin
        seen = 1'b1;
        compare({tag, ".latency"}, 32'(n), exp.lat);
        compare({tag, ".rdata"}, obsRdata, exp.rdata);
        compare({tag, ".fault"}, 32'(obsFault), 32'(exp.fault));
      end
    end
    if (!seen) begin
      compare({tag, ".timeout"}, 32'd0, 32'd1);
      return;
    end
    stepCycle();
    compare({tag, ".pulse"}, 32'(obsValid), 32'd0);
    compare({tag, ".readyBack"}, 32'(obsReady), 32'd1);
    compare({tag, ".idle"}, 32'(obsBusy), 32'd0);
  endtask

  initial begin
    sel       = 0;
    rst       = 1'b0;
    reqValid  = 1'b0;
    reqWe     = 1'b0;
    reqAddr   = 32'h0;
    reqWdata  = 32'h0;
    reqFunct3 = F3_W;
    stepCycle();
    stepCycle();
    compare("reset.ready", 32'(ready0), 32'd1);
    compare("reset.busy", 32'(busy0), 32'd0);
    compare("reset.rspValid", 32'(rspValid0), 32'd0);
    compare("reset.rdata", rspRdata0, 32'h0);
    compare("reset.fault", 32'(rspFault0), 32'd0);
    rst = 1'b1;
    stepCycle();

    // Abort a store mid-WAIT; a known prior value must survive it.
    applyStimulus(1'b1, 32'h10, 32'h1111_1111, F3_W, 32'h0, 1'b0, 3);
    checkOutput("preSW10", 1'b0);
    reqWe = 1'b1; reqAddr = 32'h10; reqWdata = 32'hDEAD_BEEF; reqFunct3 = F3_W;
    reqValid = 1'b1;
    stepCycle();
    reqValid = 1'b0;
    compare("abort.busyBefore", 32'(busy0), 32'd1);
    rst = 1'b0;
    #1;
    compare("abort.busyAsync", 32'(busy0), 32'd0);
    compare("abort.readyAsync", 32'(ready0), 32'd1);
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      compare("abort.noRspInReset", 32'(rspValid0), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      compare("abort.noRspAfter", 32'(rspValid0), 32'd0);
    end
    applyStimulus(1'b0, 32'h10, 32'h0, F3_W, 32'h1111_1111, 1'b0, 3);
    checkOutput("abort.LW10", 1'b0);

    // Sign/zero extension of bytes and halves.
    applyStimulus(1'b1, 32'h20, 32'h80FF_7F01, F3_W, 32'h0, 1'b0, 3);
    checkOutput("SW20", 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, F3_B, 32'h0000_0001, 1'b0, 3);
    checkOutput("LB20", 1'b0);
    applyStimulus(1'b0, 32'h23, 32'h0, F3_B, 32'hFFFF_FF80, 1'b0, 3);
    checkOutput("LB23", 1'b0);
    applyStimulus(1'b0, 32'h23, 32'h0, F3_BU, 32'h0000_0080, 1'b0, 3);
    checkOutput("LBU23", 1'b0);
    applyStimulus(1'b0, 32'h22, 32'h0, F3_H, 32'hFFFF_80FF, 1'b0, 3);
    checkOutput("LH22", 1'b0);
    applyStimulus(1'b0, 32'h22, 32'h0, F3_HU, 32'h0000_80FF, 1'b0, 3);
    checkOutput("LHU22", 1'b0);

    // Partial stores merge into an existing word.
    applyStimulus(1'b1, 32'h30, 32'h0, F3_W, 32'h0, 1'b0, 3);
    checkOutput("SW30", 1'b0);
    applyStimulus(1'b1, 32'h31, 32'hFFFF_FFAA, F3_B, 32'h0, 1'b0, 3);
    checkOutput("SB31", 1'b0);
    applyStimulus(1'b1, 32'h32, 32'hFFFF_1234, F3_H, 32'h0, 1'b0, 3);
    checkOutput("SH32", 1'b0);
    applyStimulus(1'b0, 32'h30, 32'h0, F3_W, 32'h1234_AA00, 1'b0, 3);
    checkOutput("LW30", 1'b0);

    // Faults respond in one cycle and leave memory untouched.
    applyStimulus(1'b1, 32'h40, 32'hCAFE_F00D, F3_W, 32'h0, 1'b0, 3);
    checkOutput("SW40", 1'b0);
    applyStimulus(1'b0, 32'h41, 32'h0, F3_W, 32'h0, 1'b1, 1);
    checkOutput("faultLW41", 1'b0);
    applyStimulus(1'b1, 32'h43, 32'h0000_5555, F3_H, 32'h0, 1'b1, 1);
    checkOutput("faultSH43", 1'b0);
    applyStimulus(1'b0, 32'h40, 32'h0, 3'b011, 32'h0, 1'b1, 1);
    checkOutput("faultF3_011", 1'b0);
    applyStimulus(1'b1, 32'h40, 32'h0000_0077, F3_BU, 32'h0, 1'b1, 1);
    checkOutput("faultStoreBU", 1'b0);
    applyStimulus(1'b0, 32'h40, 32'h0, F3_W, 32'hCAFE_F00D, 1'b0, 3);
    checkOutput("LW40", 1'b0);

    // Aliasing: word index ignores address bits above ADDR_W+1.
    applyStimulus(1'b1, 32'h1000, 32'h0000_0055, F3_W, 32'h0, 1'b0, 3);
    checkOutput("SW1000", 1'b0);
    applyStimulus(1'b0, 32'h0000, 32'h0, F3_W, 32'h0000_0055, 1'b0, 3);
    checkOutput("LW0000", 1'b0);

    // Zero and three wait states with the request held back-to-back.
    reqValid = 1'b0;
    stepCycle();
    sel = 1;
    #1;
    applyStimulus(1'b1, 32'h50, 32'h1234_5678, F3_W, 32'h0, 1'b0, 2);
    checkOutput("w0.SW50", 1'b1);
    applyStimulus(1'b0, 32'h50, 32'h0, F3_W, 32'h1234_5678, 1'b0, 2);
    checkOutput("w0.LW50", 1'b0);
    stepCycle();
    sel = 2;
    #1;
    applyStimulus(1'b1, 32'h54, 32'h8765_4321, F3_W, 32'h0, 1'b0, 5);
    checkOutput("w3.SW54", 1'b1);
    applyStimulus(1'b0, 32'h56, 32'h0, F3_H, 32'hFFFF_8765, 1'b0, 5);
    checkOutput("w3.LH56", 1'b1);
    applyStimulus(1'b0, 32'h57, 32'h0, F3_W, 32'h0, 1'b1, 1);
    checkOutput("w3.faultLW57", 1'b0);

    stepCycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
